// File: rtl/gsim_param.sv
// Gauss-Seidel solver for the banded Toeplitz system with diagonal 20 and bands -13/+6/-1.
// Streams b in, iterates in place through a 5-stage per-variable datapath, then streams x out.
module gsim_param #(
    parameter int N     = 16,
    parameter int B_W   = 16,
    parameter int FRAC  = 16,
    parameter int ACC_W = 40,
    parameter int X_W   = 32,
    parameter int IT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_en,
    input  logic [B_W-1:0]   b_in,
    input  logic [IT_W-1:0]  iter_max,
    input  logic [ACC_W-1:0] tol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [X_W-1:0]   x_out,
    output logic             busy,
    output logic             converged,
    output logic [IT_W-1:0]  sweeps
);

    localparam int KW = $clog2(N);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        ST_RECV = 2'd0,
        ST_CALC = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    typedef logic signed [ACC_W-1:0] acc_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [2:0]       stage_q, stage_d;
    logic [IT_W-1:0]  sweep_q, sweep_d;
    logic [IT_W-1:0]  iter_max_q, iter_max_d;
    logic [ACC_W-1:0] tol_q, tol_d;
    logic [ACC_W-1:0] maxd_q, maxd_d;
    acc_t             r1_q, r1_d, r2_q, r2_d, r3_q, r3_d, t_q, t_d;
    logic             converged_q, converged_d;
    logic             out_valid_q, busy_q;
    logic [X_W-1:0]   x_out_q, x_out_d;

    logic [B_W-1:0]   b_mem_q [N];
    acc_t             x_mem_q [N];
    logic             b_we_s, x_we_s;
    acc_t             x_wdata_s;

    logic [KW-1:0]    km1_s, km2_s, km3_s, kp1_s, kp2_s, kp3_s;
    acc_t             xm1_s, xm2_s, xm3_s, xp1_s, xp2_s, xp3_s;
    acc_t             sum1_s, sum2_s, b_sh_s, xn_s, diff_s;
    logic [ACC_W-1:0] absd_s, maxd_new_s;
    logic [IT_W-1:0]  sweep_inc_s;

    // Datapath: neighbour fetch with band-edge zeroing, divide-by-20 approximation, delta tracking.
    always_comb begin
        km1_s = k_q - KW'(1);
        km2_s = k_q - KW'(2);
        km3_s = k_q - KW'(3);
        kp1_s = k_q + KW'(1);
        kp2_s = k_q + KW'(2);
        kp3_s = k_q + KW'(3);
        xm1_s = (k_q >= KW'(1))     ? x_mem_q[km1_s] : '0;
        xm2_s = (k_q >= KW'(2))     ? x_mem_q[km2_s] : '0;
        xm3_s = (k_q >= KW'(3))     ? x_mem_q[km3_s] : '0;
        xp1_s = (k_q <= KW'(N - 2)) ? x_mem_q[kp1_s] : '0;
        xp2_s = (k_q <= KW'(N - 3)) ? x_mem_q[kp2_s] : '0;
        xp3_s = (k_q <= KW'(N - 4)) ? x_mem_q[kp3_s] : '0;
        sum1_s = xm1_s + xp1_s;
        sum2_s = xm2_s + xp2_s;
        b_sh_s = acc_t'($signed(b_mem_q[k_q])) <<< FRAC;
        // t * (1 + 1/16)(1 + 1/256) was built in s2/s3; these taps finish t/20.
        xn_s   = (t_q >>> 5'd5) + (t_q >>> 5'd6) + (t_q >>> 5'd21) + (t_q >>> 5'd22);
        diff_s = xn_s - x_mem_q[k_q];
        absd_s = diff_s[ACC_W-1] ? -diff_s : diff_s;
        if (k_q == '0) begin
            maxd_new_s = absd_s;
        end else if (absd_s > maxd_q) begin
            maxd_new_s = absd_s;
        end else begin
            maxd_new_s = maxd_q;
        end
        sweep_inc_s = sweep_q + IT_W'(1);
    end

    // Next-state logic for the RECV / CALC / SEND sequencer.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        stage_d     = stage_q;
        sweep_d     = sweep_q;
        iter_max_d  = iter_max_q;
        tol_d       = tol_q;
        maxd_d      = maxd_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        r3_d        = r3_q;
        t_d         = t_q;
        converged_d = converged_q;
        x_out_d     = x_out_q;
        b_we_s      = 1'b0;
        x_we_s      = 1'b0;
        x_wdata_s   = '0;
        case (state_q)
            ST_RECV: begin
                if (in_en) begin
                    b_we_s = 1'b1;
                    x_we_s = 1'b1;
                    if (k_q == '0) begin
                        iter_max_d = (iter_max == '0) ? IT_W'(1) : iter_max;
                        tol_d      = tol;
                    end else begin
                        iter_max_d = iter_max_q;
                    end
                    if (k_q == K_LAST) begin
                        state_d     = ST_CALC;
                        k_d         = '0;
                        stage_d     = 3'd0;
                        sweep_d     = '0;
                        converged_d = 1'b0;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end else begin
                    k_d = k_q;
                end
            end
            ST_CALC: begin
                case (stage_q)
                    3'd0: begin
                        r1_d    = xm3_s + xp3_s + b_sh_s;
                        r2_d    = (sum2_s <<< 2) + (sum2_s <<< 1);
                        r3_d    = (sum1_s <<< 3) + (sum1_s <<< 2) + sum1_s;
                        stage_d = 3'd1;
                    end
                    3'd1: begin
                        t_d     = r1_q - r2_q + r3_q;
                        stage_d = 3'd2;
                    end
                    3'd2: begin
                        t_d     = t_q + (t_q >>> 5'd4);
                        stage_d = 3'd3;
                    end
                    3'd3: begin
                        t_d     = t_q + (t_q >>> 5'd8);
                        stage_d = 3'd4;
                    end
                    3'd4: begin
                        x_we_s    = 1'b1;
                        x_wdata_s = xn_s;
                        maxd_d    = maxd_new_s;
                        stage_d   = 3'd0;
                        if (k_q == K_LAST) begin
                            sweep_d = sweep_inc_s;
                            k_d     = '0;
                            // Index 0 is never the one being written here, so the read is current.
                            if (maxd_new_s <= tol_q) begin
                                converged_d = 1'b1;
                                state_d     = ST_SEND;
                                x_out_d     = x_mem_q[0][X_W-1:0];
                            end else if (sweep_inc_s == iter_max_q) begin
                                converged_d = 1'b0;
                                state_d     = ST_SEND;
                                x_out_d     = x_mem_q[0][X_W-1:0];
                            end else begin
                                state_d = ST_CALC;
                            end
                        end else begin
                            k_d = k_q + KW'(1);
                        end
                    end
                    default: begin
                        stage_d = 3'd0;
                    end
                endcase
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (k_q == K_LAST) begin
                        state_d = ST_RECV;
                        k_d     = '0;
                    end else begin
                        k_d     = k_q + KW'(1);
                        x_out_d = x_mem_q[kp1_s][X_W-1:0];
                    end
                end else begin
                    k_d = k_q;
                end
            end
            default: begin
                state_d = ST_RECV;
                k_d     = '0;
            end
        endcase
    end

    // Control and datapath registers; reset discards any run in progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_RECV;
            k_q         <= '0;
            stage_q     <= 3'd0;
            sweep_q     <= '0;
            iter_max_q  <= '0;
            tol_q       <= '0;
            maxd_q      <= '0;
            r1_q        <= '0;
            r2_q        <= '0;
            r3_q        <= '0;
            t_q         <= '0;
            converged_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            x_out_q     <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            stage_q     <= stage_d;
            sweep_q     <= sweep_d;
            iter_max_q  <= iter_max_d;
            tol_q       <= tol_d;
            maxd_q      <= maxd_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            r3_q        <= r3_d;
            t_q         <= t_d;
            converged_q <= converged_d;
            out_valid_q <= (state_d == ST_SEND);
            busy_q      <= (state_d == ST_CALC);
            x_out_q     <= x_out_d;
        end
    end

    // b/x storage is not cleared by reset, only write-blocked while it is asserted.
    always_ff @(posedge clk) begin
        if (reset && b_we_s) begin
            b_mem_q[k_q] <= b_in;
        end
        if (reset && x_we_s) begin
            x_mem_q[k_q] <= x_wdata_s;
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign converged = converged_q;
    assign sweeps    = sweep_q;
    assign x_out     = x_out_q;

endmodule

// File: tb/tb_gsim_param.sv
// Directed bench for gsim_param: zero system, sweep-limit and early exits, gaps/backpressure,
// reset mid-run and iter_max=0, against a bit-exact Gauss-Seidel reference.
module tb_gsim_param;

    localparam int N = 16;

    typedef logic signed [39:0] acc_t;
    typedef logic signed [15:0] bvec_t [N];
    typedef acc_t               xvec_t [N];
    typedef logic [31:0]        ovec_t [N];

    logic        clk = 1'b0;
    logic        reset;
    logic        in_en;
    logic [15:0] b_in;
    logic [7:0]  iter_max;
    logic [39:0] tol;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] x_out;
    logic        busy;
    logic        converged;
    logic [7:0]  sweeps;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    gsim_param dut (
        .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in), .iter_max(iter_max),
        .tol(tol), .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out),
        .busy(busy), .converged(converged), .sweeps(sweeps)
    );

    // Reference: in-place Gauss-Seidel with the truncating t/20 approximation, 40-bit wrap.
    task automatic model_run(input bvec_t bv, input int itm, input logic [39:0] tl,
                             output xvec_t xr, output int sw, output bit conv);
        acc_t x [N];
        acc_t bs, n1, n2, n3, s, t2, t3, xn, d;
        logic [39:0] ud, maxd;
        int ie;
        ie = (itm == 0) ? 1 : itm;
        for (int i = 0; i < N; i++) x[i] = '0;
        sw = 0;
        conv = 1'b0;
        while (sw < 300) begin
            maxd = '0;
            for (int k = 0; k < N; k++) begin
                bs = bv[k];
                n1 = ((k >= 1) ? x[k-1] : acc_t'(0)) + ((k <= N-2) ? x[k+1] : acc_t'(0));
                n2 = ((k >= 2) ? x[k-2] : acc_t'(0)) + ((k <= N-3) ? x[k+2] : acc_t'(0));
                n3 = ((k >= 3) ? x[k-3] : acc_t'(0)) + ((k <= N-4) ? x[k+3] : acc_t'(0));
                s  = bs * 65536 + 13 * n1 - 6 * n2 + n3;
                t2 = s + (s >>> 4);
                t3 = t2 + (t2 >>> 8);
                xn = (t3 >>> 5) + (t3 >>> 6) + (t3 >>> 21) + (t3 >>> 22);
                d  = xn - x[k];
                ud = d[39] ? -d : d;
                if (ud > maxd) maxd = ud;
                x[k] = xn;
            end
            sw++;
            if (maxd <= tl) begin
                conv = 1'b1;
                break;
            end
            if (sw == ie) break;
        end
        for (int i = 0; i < N; i++) xr[i] = x[i];
    endtask

    // Loads b; iter_max/tol carry junk after b[0] so a late latch would be visible.
    task automatic load(input bvec_t bv, input int itm, input logic [39:0] tl, input bit gaps);
        for (int k = 0; k < N; k++) begin
            if (gaps && (k % 3 == 1)) begin
                repeat (k % 2 + 1) begin
                    @(negedge clk);
                    in_en = 1'b0;
                    b_in  = 16'h7fff;
                end
            end
            @(negedge clk);
            in_en    = 1'b1;
            b_in     = bv[k];
            iter_max = (k == 0) ? itm[7:0] : 8'd3;
            tol      = (k == 0) ? tl : 40'hff_ffff_ffff;
        end
        @(negedge clk);
        in_en = 1'b0;
        b_in  = 16'h0000;
    endtask

    task automatic wait_valid(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b1;
        while (out_valid !== 1'b1) begin
            @(negedge clk);
            cyc++;
            if (cyc > 30000) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic collect(input int stall_at, output ovec_t got, output int xfers, output bit stable);
        stable = 1'b1;
        xfers  = 0;
        for (int i = 0; i < N; i++) got[i] = '0;
        for (int i = 0; i < N; i++) begin
            if (out_valid !== 1'b1) break;
            got[i] = x_out;
            if (i == stall_at) begin
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (x_out !== got[i] || out_valid !== 1'b1) stable = 1'b0;
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            xfers++;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_en = 1'b0; out_ready = 1'b0;
        b_in = '0; iter_max = '0; tol = '0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
        checks++; if (converged !== 1'b0) $display("FAIL reset_converged got %b want 0", converged); else passes++;
        checks++; if (sweeps !== 8'd0) $display("FAIL reset_sweeps got %0d want 0", sweeps); else passes++;
        reset = 1'b1;
    endtask

    task automatic test_zero(input string tag);
        bvec_t bv; int cyc; bit ok; ovec_t got; int xf; bit st;
        for (int i = 0; i < N; i++) bv[i] = '0;
        load(bv, 100, 40'd0, 1'b0);
        wait_valid(cyc, ok);
        checks++; if (!ok) $display("FAIL %s_timeout out_valid never rose", tag); else passes++;
        checks++; if (cyc != 80) $display("FAIL %s_latency got %0d want 80", tag, cyc); else passes++;
        checks++; if (converged !== 1'b1) $display("FAIL %s_converged got %b want 1", tag, converged); else passes++;
        checks++; if (sweeps !== 8'd1) $display("FAIL %s_sweeps got %0d want 1", tag, sweeps); else passes++;
        collect(-1, got, xf, st);
        checks++; if (xf != N) $display("FAIL %s_xfers got %0d want %0d", tag, xf, N); else passes++;
        for (int i = 0; i < N; i++) begin
            checks++; if (got[i] !== 32'd0) $display("FAIL %s_x[%0d] got %h want 0", tag, i, got[i]); else passes++;
        end
    endtask

    task automatic test_model(input string tag, input bvec_t bv, input int itm, input logic [39:0] tl,
                              input bit gaps, input int stall_at, output logic [7:0] dut_sweeps);
        xvec_t xm; int msw; bit mconv; int cyc; bit ok; ovec_t got; int xf; bit st;
        model_run(bv, itm, tl, xm, msw, mconv);
        load(bv, itm, tl, gaps);
        checks++; if (busy !== 1'b1) $display("FAIL %s_busy got %b want 1", tag, busy); else passes++;
        wait_valid(cyc, ok);
        checks++; if (!ok) $display("FAIL %s_timeout out_valid never rose", tag); else passes++;
        checks++; if (cyc != 5 * N * msw) $display("FAIL %s_latency got %0d want %0d", tag, cyc, 5 * N * msw); else passes++;
        checks++; if (sweeps !== msw[7:0]) $display("FAIL %s_sweeps got %0d want %0d", tag, sweeps, msw); else passes++;
        checks++; if (converged !== mconv) $display("FAIL %s_converged got %b want %b", tag, converged, mconv); else passes++;
        dut_sweeps = sweeps;
        collect(stall_at, got, xf, st);
        checks++; if (xf != N) $display("FAIL %s_xfers got %0d want %0d", tag, xf, N); else passes++;
        if (stall_at >= 0) begin
            checks++; if (st !== 1'b1) $display("FAIL %s_stall x_out not held got %b want 1", tag, st); else passes++;
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got[i] !== xm[i][31:0]) $display("FAIL %s_x[%0d] got %h want %h", tag, i, got[i], xm[i][31:0]);
            else passes++;
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL %s_idle got valid=%b busy=%b want 0 0", tag, out_valid, busy);
        else passes++;
    endtask

    task automatic test_limit();
        bvec_t bv; logic [7:0] s;
        for (int i = 0; i < N; i++) bv[i] = 16'sd1;
        test_model("limit", bv, 100, 40'd0, 1'b0, -1, s);
    endtask

    task automatic test_early();
        bvec_t bv; logic [7:0] s;
        for (int i = 0; i < N; i++) bv[i] = 16'sd1;
        test_model("early", bv, 100, 40'd64, 1'b0, -1, s);
        checks++; if (!(s < 8'd100)) $display("FAIL early_exit sweeps got %0d want <100", s); else passes++;
    endtask

    task automatic test_handshake();
        bvec_t bv; logic [7:0] s;
        for (int i = 0; i < N; i++) bv[i] = 16'(i * 37 - 200);
        test_model("handshake", bv, 5, 40'd0, 1'b1, 5, s);
    endtask

    task automatic test_reset_mid_calc();
        bvec_t bv;
        for (int i = 0; i < N; i++) bv[i] = 16'sd1;
        load(bv, 100, 40'd0, 1'b0);
        repeat (5 * N * 2 + 3) @(negedge clk);
        checks++; if (busy !== 1'b1) $display("FAIL midcalc_busy got %b want 1", busy); else passes++;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++; if (busy !== 1'b0) $display("FAIL midcalc_reset_busy got %b want 0", busy); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL midcalc_reset_valid got %b want 0", out_valid); else passes++;
        checks++; if (sweeps !== 8'd0) $display("FAIL midcalc_reset_sweeps got %0d want 0", sweeps); else passes++;
        test_zero("zero_after_reset");
    endtask

    task automatic test_iter0();
        bvec_t bv; logic [7:0] s;
        for (int i = 0; i < N; i++) bv[i] = (i % 2 == 0) ? 16'sd100 : -16'sd100;
        test_model("iter0", bv, 0, 40'd0, 1'b0, -1, s);
        checks++; if (s !== 8'd1) $display("FAIL iter0_one_sweep got %0d want 1", s); else passes++;
    endtask

    initial begin
        test_reset();
        test_zero("zero");
        test_limit();
        test_early();
        test_handshake();
        test_reset_mid_calc();
        test_iter0();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
